multicycle_ctrl: RTL and testbench

Multi-cycle control FSM that sequences the MIPS instruction-fetch unit, register file, ALU and data memory, one instruction at a time. It latches the fetched instruction word and decodes opcode/funct. It then walks FETCH→DECODE→EXEC→MEM→WB as required by the instruction class, emitting PC, register-file, ALU and data-memory strobes. It sits between the fetch unit (`im_out_ins`, `npc_sel`, `isJump`) and the rest of the datapath, and paces data-memory accesses with a ready handshake.

---
 rtl/multicycle_ctrl.sv | 176 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// multicycle_ctrl : multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB)
// Optional macro MC_ILLEGAL_TRAP_EN halts on illegal opcodes.  Rev 1.0
// ============================================================================
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      ins,
  input  logic             alu_zero,
  input  logic             dm_ready,
  output logic             ir_we,
  output logic             pc_we,
  output logic             npc_sel,
  output logic             isJump,
  output logic [1:0]       ext_op,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_we,
  output logic             dm_re,
  output logic             dm_we,
  output logic [2:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  state_t      cur_state, nxt_state;
  logic [31:0] ir;
  logic [5:0]  op, funct;
  logic        is_addu, is_subu, is_ori, is_lui, is_lw, is_sw, is_beq, is_j;
  logic        is_nop, is_legal;

  assign op    = ir[31:26];
  assign funct = ir[5:0];

  assign is_addu  = (op == 6'b000000) && (funct == 6'b100001);
  assign is_subu  = (op == 6'b000000) && (funct == 6'b100011);
  assign is_ori   = (op == 6'b001101);
  assign is_lui   = (op == 6'b001111);
  assign is_lw    = (op == 6'b100011);
  assign is_sw    = (op == 6'b101011);
  assign is_beq   = (op == 6'b000100);
  assign is_j     = (op == 6'b000010);
  assign is_nop   = (ir == 32'd0);
  assign is_legal = is_addu | is_subu | is_ori | is_lui | is_lw | is_sw |
                    is_beq | is_j | is_nop;

  assign state = cur_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= S_FETCH;
      ir        <= 32'd0;
      instret   <= '0;
    end else begin
      cur_state <= nxt_state;
      if (ir_we) ir <= ins;
      if (pc_we) instret <= instret + CNT_W'(1);
    end
  end

`ifdef MC_ILLEGAL_TRAP_EN
  logic illegal_q;
  always_ff @(posedge clk) begin
    if (rst)
      illegal_q <= 1'b0;
    else if (cur_state == S_DECODE && !is_legal)
      illegal_q <= 1'b1;
  end
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  // alu_zero only steers the NPC; the controller pulses pc_we either way.
  logic unused_ok;
  assign unused_ok = alu_zero;

  always_comb begin
    nxt_state  = cur_state;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    npc_sel    = 1'b0;
    isJump     = 1'b0;
    ext_op     = 2'b00;
    alu_src    = 1'b0;
    alu_op     = 2'b00;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_we     = 1'b0;
    dm_re      = 1'b0;
    dm_we      = 1'b0;
    if (!rst) begin
      // ALU/extender selects stay stable from EXEC through write-back.
      if (cur_state == S_EXEC || cur_state == S_MEM || cur_state == S_WB) begin
        if (is_subu || is_beq)     alu_op = 2'b01;
        else if (is_ori || is_lui) alu_op = 2'b10;
        alu_src = !(is_addu || is_subu || is_beq);
        if (is_lui)              ext_op = 2'b10;
        else if (is_lw || is_sw) ext_op = 2'b01;
      end
      case (cur_state)
        S_FETCH: begin
          ir_we     = 1'b1;
          nxt_state = S_DECODE;
        end
        S_DECODE: begin
          if (is_j) begin
            isJump    = 1'b1;
            pc_we     = 1'b1;
            nxt_state = S_FETCH;
          end else if (is_nop) begin
            pc_we     = 1'b1;
            nxt_state = S_FETCH;
          end else if (!is_legal) begin
`ifdef MC_ILLEGAL_TRAP_EN
            nxt_state = S_HALT;
`else
            pc_we     = 1'b1;
            nxt_state = S_FETCH;
`endif
          end else begin
            nxt_state = S_EXEC;
          end
        end
        S_EXEC: begin
          if (is_beq) begin
            npc_sel   = 1'b1;
            pc_we     = 1'b1;
            nxt_state = S_FETCH;
          end else if (is_lw || is_sw) begin
            nxt_state = S_MEM;
          end else begin
            nxt_state = S_WB;
          end
        end
        S_MEM: begin
          dm_re = is_lw;
          dm_we = is_sw;
          if (dm_ready) begin
            if (is_sw) begin
              pc_we     = 1'b1;
              nxt_state = S_FETCH;
            end else begin
              nxt_state = S_WB;
            end
          end
        end
        S_WB: begin
          reg_we     = 1'b1;
          pc_we      = 1'b1;
          reg_dst    = is_addu || is_subu;
          mem_to_reg = is_lw;
          nxt_state  = S_FETCH;
        end
        S_HALT:  nxt_state = S_HALT;
        default: nxt_state = S_FETCH;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// tb_multicycle_ctrl: directed + random instruction stream checked against a
// per-instruction timing model (CPI table, strobe windows, retire counter).
module tb_multicycle_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   ins;
  logic          alu_zero, dm_ready;
  logic          ir_we, pc_we, npc_sel, isJump, alu_src, reg_dst, mem_to_reg;
  logic          reg_we, dm_re, dm_we, illegal;
  logic [1:0]    ext_op, alu_op;
  logic [2:0]    state;
  logic [CW-1:0] instret;

  multicycle_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .ins(ins), .alu_zero(alu_zero), .dm_ready(dm_ready),
    .ir_we(ir_we), .pc_we(pc_we), .npc_sel(npc_sel), .isJump(isJump),
    .ext_op(ext_op), .alu_src(alu_src), .alu_op(alu_op), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_we(reg_we), .dm_re(dm_re), .dm_we(dm_we),
    .state(state), .illegal(illegal), .instret(instret)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int model_cnt = 0;

  // instruction classes
  localparam int C_ADDU = 0, C_SUBU = 1, C_ORI = 2, C_LUI = 3, C_LW = 4,
                 C_SW = 5, C_BEQ = 6, C_J = 7, C_NOP = 8, C_ILL = 9;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] gen(input int cls);
    logic [31:0] r;
    logic [5:0]  o;
    r = $urandom();
    case (cls)
      C_ADDU: return {6'b000000, r[19:0], 6'b100001};
      C_SUBU: return {6'b000000, r[19:0], 6'b100011};
      C_ORI:  return {6'b001101, r[25:0]};
      C_LUI:  return {6'b001111, r[25:0]};
      C_LW:   return {6'b100011, r[25:0]};
      C_SW:   return {6'b101011, r[25:0]};
      C_BEQ:  return {6'b000100, r[25:0]};
      C_J:    return {6'b000010, r[25:0]};
      C_NOP:  return 32'd0;
      default: begin
        o = r[31:26];
        if (o == 6'd0 || o == 6'd13 || o == 6'd15 || o == 6'd35 ||
            o == 6'd43 || o == 6'd4 || o == 6'd2)
          o = 6'b111111;
        return {o, r[25:0]};
      end
    endcase
  endfunction

  // Called at a falling edge; returns at the falling edge after retirement.
  task automatic run_instr(input int cls, input logic [31:0] word, input int w, input int az);
    int  cpi, last, exp_st, exp_op, exp_ext;
    bit  is_mem, writes, in_mem;
    is_mem = (cls == C_LW || cls == C_SW);
    writes = (cls <= C_LW);
    case (cls)
      C_LW:                         cpi = 5 + w;
      C_SW:                         cpi = 4 + w;
      C_BEQ:                        cpi = 3;
      C_J, C_NOP, C_ILL:            cpi = 2;
      default:                      cpi = 4;
    endcase
    last = cpi - 1;
    for (int k = 0; k < cpi; k++) begin
      ins      = (k == 0) ? word : $urandom();
      alu_zero = (az < 0) ? 1'($urandom_range(0, 1)) : 1'(az);
      in_mem   = is_mem && k >= 3 && k <= 3 + w;
      if (in_mem) dm_ready = (k == 3 + w);
      else        dm_ready = 1'($urandom_range(0, 1));
      #1;
      if (k == 0)      exp_st = 0;
      else if (k == 1) exp_st = 1;
      else if (k == 2) exp_st = 2;
      else if (in_mem) exp_st = 3;
      else             exp_st = 4;
      if (k == 0) chk("instret", 32'(instret), 32'(model_cnt));
      chk("state",  32'(state),  32'(exp_st));
      chk("ir_we",  32'(ir_we),  32'(k == 0));
      chk("pc_we",  32'(pc_we),  32'(k == last));
      chk("reg_we", 32'(reg_we), 32'(writes && k == last));
      chk("dm_re",  32'(dm_re),  32'(cls == C_LW && in_mem));
      chk("dm_we",  32'(dm_we),  32'(cls == C_SW && in_mem));
      chk("isJump", 32'(isJump), 32'(cls == C_J && k == 1));
      chk("npc_sel",32'(npc_sel),32'(cls == C_BEQ && k == 2));
      chk("illegal",32'(illegal),32'(0));
      if (k >= 2) begin
        exp_op = (cls == C_SUBU || cls == C_BEQ) ? 1 :
                 (cls == C_ORI  || cls == C_LUI) ? 2 : 0;
        chk("alu_op",  32'(alu_op),  32'(exp_op));
        chk("alu_src", 32'(alu_src), 32'(!(cls == C_ADDU || cls == C_SUBU || cls == C_BEQ)));
        if (cls == C_ORI || cls == C_LUI || is_mem) begin
          exp_ext = (cls == C_LUI) ? 2 : (is_mem ? 1 : 0);
          chk("ext_op", 32'(ext_op), 32'(exp_ext));
        end
      end
      if (writes && k == last) begin
        chk("reg_dst",    32'(reg_dst),    32'(cls == C_ADDU || cls == C_SUBU));
        chk("mem_to_reg", 32'(mem_to_reg), 32'(cls == C_LW));
      end
      @(negedge clk);
    end
    model_cnt = (model_cnt + 1) % (1 << CW);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      ins = $urandom();
      dm_ready = 1'b1;
      @(negedge clk);
      #1;
      chk("rst_state",   32'(state),   32'(0));
      chk("rst_instret", 32'(instret), 32'(0));
      chk("rst_strobes", 32'({ir_we, pc_we, reg_we, dm_re, dm_we, isJump, npc_sel}), 32'(0));
      chk("rst_illegal", 32'(illegal), 32'(0));
    end
    @(negedge clk);
    rst = 1'b0;
    model_cnt = 0;
  endtask

  initial begin
    int cls, w;
    ins = 32'd0; alu_zero = 1'b0; dm_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    do_reset(2);

    run_instr(C_LUI, 32'h3C011234, 0, -1);
    run_instr(C_BEQ, 32'h10220003, 0, 1);
    run_instr(C_BEQ, 32'h10220003, 0, 0);
    run_instr(C_LW,  32'h8C430004, 3, -1);
    run_instr(C_SW,  32'hAC430004, 0, -1);

    // second sw abandoned by reset while waiting in MEM
    for (int k = 0; k < 4; k++) begin
      ins = (k == 0) ? 32'hAC430004 : $urandom();
      dm_ready = 1'b0;
      #1;
      if (k == 3) chk("mid_mem_dm_we", 32'(dm_we), 32'(1));
      @(negedge clk);
    end
    rst = 1'b1; dm_ready = 1'b1;
    #1;
    chk("rst_mem_dm_we", 32'(dm_we), 32'(0));
    chk("rst_mem_pc_we", 32'(pc_we), 32'(0));
    @(negedge clk);
    rst = 1'b0; model_cnt = 0;
    #1;
    chk("rst_mem_state",   32'(state),   32'(0));
    chk("rst_mem_instret", 32'(instret), 32'(0));

    run_instr(C_J,   32'h08000C00, 0, -1);
    run_instr(C_NOP, 32'h00000000, 0, -1);
    run_instr(C_ADDU, gen(C_ADDU), 0, -1);
    run_instr(C_SUBU, gen(C_SUBU), 0, -1);
    run_instr(C_ORI,  gen(C_ORI),  0, -1);

`ifdef MC_ILLEGAL_TRAP_EN
    ins = 32'hFC000000; dm_ready = 1'b1;
    #1;
    chk("trap_fetch", 32'(state), 32'(0));
    @(negedge clk);
    ins = $urandom();
    #1;
    chk("trap_decode_pc_we", 32'(pc_we), 32'(0));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ins = $urandom(); dm_ready = 1'($urandom_range(0, 1));
      #1;
      chk("trap_state",   32'(state),   32'(7));
      chk("trap_illegal", 32'(illegal), 32'(1));
      chk("trap_strobes", 32'({ir_we, pc_we, reg_we, dm_re, dm_we}), 32'(0));
      chk("trap_instret", 32'(instret), 32'(model_cnt));
    end
    @(negedge clk);
    do_reset(1);
`else
    run_instr(C_ILL, 32'hFC000000, 0, -1);
    run_instr(C_ILL, 32'h00221820, 0, -1);
`endif

    // random stream; CW=4 makes instret wrap several times
    for (int n = 0; n < 60; n++) begin
      cls = $urandom_range(0, 8);
      w   = $urandom_range(0, 3);
      run_instr(cls, gen(cls), w, -1);
    end
`ifndef MC_ILLEGAL_TRAP_EN
    for (int n = 0; n < 5; n++) run_instr(C_ILL, gen(C_ILL), 0, -1);
`endif
    #1;
    chk("final_instret", 32'(instret), 32'(model_cnt));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
